pam_threshold_demod: RTL and testbench

//  Downstream of the m-sequence synchroniser in the threshold PAM receiver. Takes the

---
 rtl/pam_threshold_demod_if.sv | 28 ++
 rtl/pam_threshold_demod.sv | 233 +++++++++++++++++++++++
 tb/tb_pam_threshold_demod.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pam_threshold_demod_if.sv
// Sample-in / byte-out handshake bundle for the PAM-4 threshold demodulator.
// The slave modport is the demodulator; the master modport drives samples and accepts bytes.
interface pam_threshold_demod_if #(
  parameter int AD_CVER_WIDTH = 12
);
  logic                     syn_demodu_valid;
  logic [AD_CVER_WIDTH-1:0] syn_demodu_data;
  logic                     syn_demodu_ready;
  logic                     demod_valid;
  logic                     demod_ready;
  logic [7:0]               demod_data;
  logic                     demod_last;
  logic                     pilot_err;
  logic                     ovf_err;
  logic                     frame_abort;

  modport slave (
    input  syn_demodu_valid, syn_demodu_data, demod_ready,
    output syn_demodu_ready, demod_valid, demod_data, demod_last,
           pilot_err, ovf_err, frame_abort
  );

  modport master (
    output syn_demodu_valid, syn_demodu_data, demod_ready,
    input  syn_demodu_ready, demod_valid, demod_data, demod_last,
           pilot_err, ovf_err, frame_abort
  );
endinterface

// File: rtl/pam_threshold_demod.sv
// Pilot-derived thresholds slice data samples into Gray PAM-4 symbols, packed 4 per byte into a FIFO.
// Byte is pushed 3 cycles after its 4th sample; upstream never stalls, so a push into a full FIFO drops.
module pam_threshold_demod #(
  parameter int AD_CVER_WIDTH = 12,
  parameter int LENGTH_PILOT  = 16,
  parameter int LENGTH_DATA   = 1024,
  parameter int FIFO_DEPTH    = 16
) (
  input logic                  clk,
  input logic                  arst,
  pam_threshold_demod_if.slave bus
);

  localparam int W  = AD_CVER_WIDTH;
  localparam int PS = $clog2(LENGTH_PILOT / 2);
  localparam int SW = W + PS;
  localparam int CW = ($clog2(LENGTH_DATA) > $clog2(LENGTH_PILOT)) ?
                      $clog2(LENGTH_DATA) : $clog2(LENGTH_PILOT);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PILOT, S_DATA} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]  sum_lo_q, sum_lo_d, sum_hi_q, sum_hi_d;
  logic           go1_q, go1_d, go2_q, go2_d;
  logic           frame_abort_q, frame_abort_d;
  logic           pilot_err_q, pilot_err_d;
  logic           ovf_err_q, ovf_err_d;
  logic [W-1:0]   lo_q, lo_d, span_q, span_d;
  logic [W-1:0]   t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
  logic [W-1:0]   p1_x_q, p1_x_d, p2_x_q, p2_x_d;
  logic           p1_vld_q, p1_vld_d, p1_end_q, p1_end_d, p1_last_q, p1_last_d;
  logic           p2_vld_q, p2_vld_d, p2_end_q, p2_end_d, p2_last_q, p2_last_d;
  logic [7:0]     pack_q, pack_d, push_dat_q, push_dat_d;
  logic           push_q, push_d, push_last_q, push_last_d;
  logic [AW:0]    wr_q, wr_d, rd_q, rd_d, fifo_cnt;
  logic [8:0]     mem_q [FIFO_DEPTH];

  logic           pilot_start, in_vld, in_end, in_last;
  logic [W-1:0]   x, lo_w, hi_w, q_w;
  logic [W+9:0]   prod;
  logic [1:0]     sym;
  logic [7:0]     byte_w;
  logic           empty, full, pop, wr_en;

  // Offset binary turns the signed sample into an unsigned level for all later arithmetic.
  assign x = {~bus.syn_demodu_data[W-1], bus.syn_demodu_data[W-2:0]};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sum_lo_d      = sum_lo_q;
    sum_hi_d      = sum_hi_q;
    go1_d         = 1'b0;
    frame_abort_d = 1'b0;
    pilot_start   = 1'b0;
    in_vld        = 1'b0;
    in_end        = 1'b0;
    in_last       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.syn_demodu_valid) begin
          pilot_start = 1'b1;
          sum_lo_d    = SW'(x);
          sum_hi_d    = '0;
          cnt_d       = CW'(1);
          state_d     = S_PILOT;
        end
      end
      S_PILOT: begin
        if (bus.syn_demodu_valid) begin
          if (cnt_q < CW'(LENGTH_PILOT / 2)) sum_lo_d = sum_lo_q + SW'(x);
          else                               sum_hi_d = sum_hi_q + SW'(x);
          if (cnt_q == CW'(LENGTH_PILOT - 1)) begin
            state_d = S_DATA;
            cnt_d   = '0;
            go1_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          frame_abort_d = 1'b1;
          cnt_d         = '0;
          state_d       = S_IDLE;
        end
      end
      S_DATA: begin
        if (bus.syn_demodu_valid) begin
          in_vld  = 1'b1;
          in_end  = (cnt_q[1:0] == 2'b11);
          in_last = (cnt_q == CW'(LENGTH_DATA - 1));
          if (in_last) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          frame_abort_d = 1'b1;
          cnt_d         = '0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // Threshold stage 1: pilot averages and span; stage 2: the three slicing levels.
    lo_w        = W'(sum_lo_q >> PS);
    hi_w        = W'(sum_hi_q >> PS);
    go2_d       = go1_q;
    lo_d        = go1_q ? lo_w : lo_q;
    span_d      = span_q;
    pilot_err_d = pilot_err_q;
    if (pilot_start) pilot_err_d = 1'b0;
    if (go1_q) begin
      span_d      = (hi_w > lo_w) ? (hi_w - lo_w) : '0;
      pilot_err_d = (hi_w <= lo_w);
    end
    prod = (W + 10)'(span_q) * (W + 10)'(683);
    q_w  = W'(prod >> 12);
    t1_d = go2_q ? (lo_q + q_w)             : t1_q;
    t2_d = go2_q ? (lo_q + (span_q >> 1))   : t2_q;
    t3_d = go2_q ? (lo_q + span_q - q_w)    : t3_q;

    // Two-stage sample delay lines up the first data sample with fresh thresholds.
    p1_x_d    = x;
    p1_vld_d  = in_vld;
    p1_end_d  = in_end;
    p1_last_d = in_last;
    p2_x_d    = p1_x_q;
    p2_vld_d  = p1_vld_q;
    p2_end_d  = p1_end_q;
    p2_last_d = p1_last_q;

    if      (p2_x_q < t1_q) sym = 2'b00;
    else if (p2_x_q < t2_q) sym = 2'b01;
    else if (p2_x_q < t3_q) sym = 2'b11;
    else                    sym = 2'b10;
    byte_w      = {pack_q[5:0], sym};
    pack_d      = p2_vld_q ? byte_w : pack_q;
    push_d      = p2_vld_q && p2_end_q;
    push_dat_d  = byte_w;
    push_last_d = p2_last_q;

    fifo_cnt  = wr_q - rd_q;
    empty     = (fifo_cnt == '0);
    full      = (fifo_cnt == (AW + 1)'(FIFO_DEPTH));
    pop       = !empty && bus.demod_ready;
    wr_en     = push_q && (!full || pop);
    wr_d      = wr_q + {{AW{1'b0}}, wr_en};
    rd_d      = rd_q + {{AW{1'b0}}, pop};
    ovf_err_d = ovf_err_q | (push_q & full & ~pop);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      sum_lo_q      <= '0;
      sum_hi_q      <= '0;
      go1_q         <= 1'b0;
      go2_q         <= 1'b0;
      frame_abort_q <= 1'b0;
      pilot_err_q   <= 1'b0;
      ovf_err_q     <= 1'b0;
      lo_q          <= '0;
      span_q        <= '0;
      t1_q          <= '0;
      t2_q          <= '0;
      t3_q          <= '0;
      p1_x_q        <= '0;
      p1_vld_q      <= 1'b0;
      p1_end_q      <= 1'b0;
      p1_last_q     <= 1'b0;
      p2_x_q        <= '0;
      p2_vld_q      <= 1'b0;
      p2_end_q      <= 1'b0;
      p2_last_q     <= 1'b0;
      pack_q        <= '0;
      push_q        <= 1'b0;
      push_dat_q    <= '0;
      push_last_q   <= 1'b0;
      wr_q          <= '0;
      rd_q          <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sum_lo_q      <= sum_lo_d;
      sum_hi_q      <= sum_hi_d;
      go1_q         <= go1_d;
      go2_q         <= go2_d;
      frame_abort_q <= frame_abort_d;
      pilot_err_q   <= pilot_err_d;
      ovf_err_q     <= ovf_err_d;
      lo_q          <= lo_d;
      span_q        <= span_d;
      t1_q          <= t1_d;
      t2_q          <= t2_d;
      t3_q          <= t3_d;
      p1_x_q        <= p1_x_d;
      p1_vld_q      <= p1_vld_d;
      p1_end_q      <= p1_end_d;
      p1_last_q     <= p1_last_d;
      p2_x_q        <= p2_x_d;
      p2_vld_q      <= p2_vld_d;
      p2_end_q      <= p2_end_d;
      p2_last_q     <= p2_last_d;
      pack_q        <= pack_d;
      push_q        <= push_d;
      push_dat_q    <= push_dat_d;
      push_last_q   <= push_last_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
    end
  end

  // Storage needs no reset: outputs are gated by the empty flag.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= {push_last_q, push_dat_q};
  end

  assign bus.demod_valid      = !empty;
  assign bus.demod_data       = empty ? 8'h00 : mem_q[rd_q[AW-1:0]][7:0];
  assign bus.demod_last       = !empty && mem_q[rd_q[AW-1:0]][8];
  assign bus.syn_demodu_ready = (fifo_cnt <= (AW + 1)'(FIFO_DEPTH - 2));
  assign bus.pilot_err        = pilot_err_q;
  assign bus.ovf_err          = ovf_err_q;
  assign bus.frame_abort      = frame_abort_q;

endmodule

// File: tb/tb_pam_threshold_demod.sv
// Randomised frames checked against a queue-based reference model of the PAM-4 threshold demodulator.
module tb_pam_threshold_demod;
  localparam int W  = 12;
  localparam int LP = 16;
  localparam int LD = 1024;
  localparam int FD = 16;

  logic clk  = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  pam_threshold_demod_if #(.AD_CVER_WIDTH(W)) bus ();

  pam_threshold_demod #(
    .AD_CVER_WIDTH(W), .LENGTH_PILOT(LP), .LENGTH_DATA(LD), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .arst(arst), .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int frame_q[$];
  int lv[4] = '{-1500, -500, 500, 1500};
  int rdy_mode = 1;
  int abort_cnt = 0;
  int pop_cnt = 0;
  int m_lo, m_hi, m_t1, m_t2, m_t3, m_perr, m_byte0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Reference: pilot averages, thresholds, Gray slicing and MSB-first packing from plain integers.
  task automatic model_frame(input int n_data, input int max_bytes);
    int slo, shi, span, q, nb, b, x, sym, byt, lst;
    slo = 0; shi = 0;
    for (int i = 0; i < LP / 2; i++) begin
      slo += frame_q[i] + 2048;
      shi += frame_q[i + LP / 2] + 2048;
    end
    m_lo   = slo / (LP / 2);
    m_hi   = shi / (LP / 2);
    span   = (m_hi > m_lo) ? m_hi - m_lo : 0;
    m_perr = (m_hi <= m_lo) ? 1 : 0;
    q      = span * 683 / 4096;
    m_t1   = m_lo + q;
    m_t2   = m_lo + span / 2;
    m_t3   = m_lo + span - q;
    nb     = n_data / 4;
    for (b = 0; b < nb; b++) begin
      byt = 0;
      for (int k = 0; k < 4; k++) begin
        x = frame_q[LP + 4 * b + k] + 2048;
        if (x < m_t1)      sym = 0;
        else if (x < m_t2) sym = 1;
        else if (x < m_t3) sym = 3;
        else               sym = 2;
        byt = byt * 4 + sym;
      end
      if (b == 0) m_byte0 = byt;
      lst = (n_data == LD && b == nb - 1) ? 1 : 0;
      if (b < max_bytes) exp_q.push_back(lst * 256 + byt);
    end
  endtask

  task automatic build_frame(input int noise, input bit swap);
    int a, c;
    frame_q.delete();
    a = swap ? 1500 : -1500;
    c = swap ? -1500 : 1500;
    for (int i = 0; i < LP; i++) frame_q.push_back(((i < LP / 2) ? a : c) + int'($urandom_range(0, 2 * noise)) - noise);
    for (int i = 0; i < LD; i++) frame_q.push_back(lv[i % 4] + int'($urandom_range(0, 2 * noise)) - noise);
  endtask

  task automatic drive(input int from, input int to);
    for (int i = from; i < to; i++) begin
      @(posedge clk); #1;
      bus.syn_demodu_valid = 1'b1;
      bus.syn_demodu_data  = W'(frame_q[i]);
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    bus.syn_demodu_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || bus.demod_valid) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drain_in_time"}, (n < 5000) ? 1 : 0, 1);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_valid"},  int'(bus.demod_valid), 0);
    chk({nm, "_data"},   int'(bus.demod_data), 0);
    chk({nm, "_last"},   int'(bus.demod_last), 0);
    chk({nm, "_perr"},   int'(bus.pilot_err), 0);
    chk({nm, "_ovf"},    int'(bus.ovf_err), 0);
    chk({nm, "_abort"},  int'(bus.frame_abort), 0);
    chk({nm, "_in_rdy"}, int'(bus.syn_demodu_ready), 1);
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.demod_ready = 1'b0;
      1:       bus.demod_ready = 1'b1;
      default: bus.demod_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic       hold_vld = 1'b0;
  logic [7:0] hold_dat;
  logic       hold_last;
  always @(negedge clk) begin
    if (arst) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld)
        chk("hold_stable", int'({bus.demod_valid, bus.demod_last, bus.demod_data}),
            int'({1'b1, hold_last, hold_dat}));
      if (bus.demod_valid && bus.demod_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) chk("unexpected_byte", int'(bus.demod_data), -1);
        else chk("byte", int'({bus.demod_last, bus.demod_data}), exp_q.pop_front());
      end
      hold_vld  = bus.demod_valid && !bus.demod_ready;
      hold_dat  = bus.demod_data;
      hold_last = bus.demod_last;
      if (bus.frame_abort) abort_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    bus.syn_demodu_valid = 1'b0;
    bus.syn_demodu_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1 arst = 1'b0;

    // Clean four-level frame; pin the model to hand-computed thresholds.
    build_frame(0, 1'b0);
    model_frame(LD, 1000);
    chk("model_lo", m_lo, 548);
    chk("model_hi", m_hi, 3548);
    chk("model_t1", m_t1, 1048);
    chk("model_t2", m_t2, 2048);
    chk("model_t3", m_t3, 3048);
    chk("model_byte0", m_byte0, 'h1E);
    chk("model_nbytes", exp_q.size(), 256);
    chk("model_lastbyte", exp_q[255], 'h11E);
    pop_cnt = 0;
    drive(0, LP + LD); go_idle();
    wait_drain("clean");
    chk("clean_pops", pop_cnt, 256);
    chk("clean_perr", int'(bus.pilot_err), 0);

    // Noisy frame with random downstream stalls.
    rdy_mode = 2;
    build_frame(400, 1'b0);
    model_frame(LD, 1000);
    pop_cnt = 0;
    drive(0, LP + LD); go_idle();
    wait_drain("noisy");
    chk("noisy_pops", pop_cnt, 256);
    chk("noisy_perr", int'(bus.pilot_err), 0);
    chk("noisy_ovf", int'(bus.ovf_err), 0);

    // Downstream blocked for the whole frame: 16 bytes held, the rest dropped.
    rdy_mode = 0;
    build_frame(0, 1'b0);
    model_frame(LD, FD);
    pop_cnt = 0;
    drive(0, LP + 60);
    @(negedge clk);
    chk("full_rdy_at14", int'(bus.syn_demodu_ready), 1);
    drive(LP + 60, LP + 64);
    @(negedge clk);
    chk("full_rdy_at15", int'(bus.syn_demodu_ready), 0);
    chk("full_ovf_before", int'(bus.ovf_err), 0);
    drive(LP + 64, LP + LD); go_idle();
    repeat (10) @(negedge clk);
    chk("full_ovf", int'(bus.ovf_err), 1);
    chk("full_valid", int'(bus.demod_valid), 1);
    chk("full_in_rdy", int'(bus.syn_demodu_ready), 0);
    rdy_mode = 1;
    wait_drain("full");
    chk("full_pops", pop_cnt, FD);
    chk("full_in_rdy_after", int'(bus.syn_demodu_ready), 1);
    @(posedge clk); #1 arst = 1'b1;
    @(posedge clk); #1 arst = 1'b0;
    @(negedge clk);
    chk("ovf_cleared_by_reset", int'(bus.ovf_err), 0);

    // Swapped pilot halves collapse all thresholds onto the low average.
    build_frame(0, 1'b1);
    model_frame(LD, 1000);
    chk("swap_model_t1", m_t1, 3548);
    chk("swap_model_t3", m_t3, 3548);
    chk("swap_model_perr", m_perr, 1);
    chk("swap_model_byte0", m_byte0, 'h02);
    pop_cnt = 0;
    drive(0, LP + LD); go_idle();
    wait_drain("swap");
    chk("swap_pops", pop_cnt, 256);
    chk("swap_perr", int'(bus.pilot_err), 1);
    build_frame(0, 1'b0);
    model_frame(LD, 1000);
    drive(0, LP / 2);
    @(negedge clk);
    chk("perr_cleared_at_pilot", int'(bus.pilot_err), 0);
    drive(LP / 2, LP + LD); go_idle();
    wait_drain("recover");
    chk("recover_perr", int'(bus.pilot_err), 0);

    // Valid drops after 102 data samples.
    abort_cnt = 0;
    build_frame(0, 1'b0);
    model_frame(102, 1000);
    pop_cnt = 0;
    drive(0, LP + 102); go_idle();
    wait_drain("abort");
    chk("abort_pulses", abort_cnt, 1);
    chk("abort_pops", pop_cnt, 25);
    build_frame(0, 1'b0);
    model_frame(LD, 1000);
    pop_cnt = 0;
    drive(0, LP + LD); go_idle();
    wait_drain("after_abort");
    chk("after_abort_pops", pop_cnt, 256);

    // Back-to-back frames with random stalls.
    rdy_mode = 2;
    pop_cnt = 0;
    build_frame(200, 1'b0);
    model_frame(LD, 1000);
    drive(0, LP + LD);
    build_frame(300, 1'b0);
    model_frame(LD, 1000);
    drive(0, LP + LD); go_idle();
    wait_drain("b2b");
    chk("b2b_pops", pop_cnt, 512);
    chk("b2b_abort_none", abort_cnt, 1);
    chk("b2b_ovf", int'(bus.ovf_err), 0);

    // Reset in the middle of data with bytes waiting in the FIFO.
    rdy_mode = 0;
    build_frame(0, 1'b0);
    drive(0, LP + 40);
    @(negedge clk);
    chk("midrst_valid_before", int'(bus.demod_valid), 1);
    @(posedge clk); #1 arst = 1'b1;
    bus.syn_demodu_valid = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    @(posedge clk); #1 arst = 1'b0;
    rdy_mode = 1;
    build_frame(0, 1'b0);
    model_frame(LD, 1000);
    pop_cnt = 0;
    drive(0, LP + LD); go_idle();
    wait_drain("post_rst");
    chk("post_rst_pops", pop_cnt, 256);
    chk("post_rst_abort_none", abort_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
